axi_slave_mem: RTL and testbench
================================

// Module: axi_slave_mem
// PURPOSE
//  AXI3 slave responder with internal byte-addressable memory: the far end of the AXI master UVC.
//  Accepts write/read bursts (FIXED/INCR/WRAP, narrow sizes, byte strobes) and returns B/R responses.
//  Serves as DUT/reference target for byte-level scoreboard checks.
//  One outstanding write and one outstanding read; the two channels run concurrently and independently.
// PARAMETERS
//  MEM_BYTES  1024  memory size in bytes; power of 2, >=64
//  ID_W       4     width of awid/bid/arid/rid
// PORTS
//  aclk     in   1   clock; all logic on posedge
//  arst     in   1   reset, asynchronous, active-low
//  awid/awaddr/awlen/awsize/awburst   in   4/32/4/3/2   write address payload
//  awvalid in 1 | awready out 1                         write address handshake
//  wid/wdata/wstrb/wlast              in   4/32/4/1    write data payload (wid, wlast informational only)
//  wvalid in 1 | wready out 1                           write data handshake
//  bid out 4 | bresp out 2 | bvalid out 1 | bready in 1 write response
//  arid/araddr/arlen/arsize/arburst   in   4/32/4/3/2   read address payload
//  arvalid in 1 | arready out 1                         read address handshake
//  rid out 4 | rdata out 32 | rresp out 2 | rlast out 1 | rvalid out 1 | rready in 1   read data
//  (awlock/awcache/awprot/arlock/arcache/arprot are not ports: ignored, left unconnected at top)
// BEHAVIOUR
//  Reset (arst=0): all outputs 0; FSMs to IDLE; memory contents NOT reset (unwritten bytes = X, unchecked).
//  Reset mid-burst: burst abandoned immediately, no response; beats already written stay in memory.
//  Write FSM  W_IDLE -> W_DATA -> W_RESP -> W_IDLE
//   W_IDLE: awready=1 (from first cycle after reset release); awvalid&awready: latch id/addr/len/size/burst; beat=0.
//   W_DATA: wready=1; each wvalid&wready writes wdata byte lanes where wstrb[i]=1 at current addr; addr advances.
//    beat==awlen ends burst (counter governs; wlast not checked) -> W_RESP next cycle.
//   W_RESP: bvalid=1, bid=latched id, bresp per CONFIGURATION; hold until bready; bvalid&bready -> W_IDLE.
//  Read FSM   R_IDLE -> R_DATA -> R_IDLE
//   R_IDLE: arready=1; arvalid&arready latches payload; rvalid=1 on the next cycle (1-cycle latency).
//   R_DATA: rdata = 32-bit word at addr aligned down to 4; rid=latched id; rlast=1 on beat arlen.
//    rvalid&!rready: rdata/rid/rresp/rlast held stable. rvalid&rready: advance; after last beat -> R_IDLE.
//  Address generation (per beat, bytes = 1<<size; size>2 clamped to 2):
//   FIXED (00): addr constant. INCR (01) and reserved (11): addr = (addr & ~(bytes-1)) + bytes.
//   WRAP (10): bound = (len+1)*bytes; addr = (addr & ~(bound-1)) | ((addr+bytes) & (bound-1)).
//    WRAP with len not in {1,3,7,15} behaves as INCR.
//  Byte lanes little-endian: lane i holds byte at (addr & ~3)+i. Narrow-write strobes are used as given (no masking).
//  Memory index = addr mod MEM_BYTES (wrap-around) unless AXI_SLV_RANGE_CHK_EN.
//  Simultaneous read and write to the same byte: read returns old value; write is visible from the next cycle.
//  No AW/AR acceptance while the corresponding FSM is busy (awready/arready=0 outside IDLE).
// CONFIGURATION
//  AXI_SLV_RANGE_CHK_EN defined: any beat with addr >= MEM_BYTES is an error beat.
//   Write: beat discarded (memory untouched), sticky flag -> bresp=2'b10 (SLVERR).
//   Read: rdata=0, rresp=2'b10 on that beat only.
//  Undefined: no range check, address wraps modulo MEM_BYTES, bresp/rresp always 2'b00 (OKAY).
// TESTING
//  1 INCR write awaddr=0x10,len=3,size=2,wstrb=F, data 0xA0..A3 -> bid=awid,bresp=0; read same -> 4 beats A0..A3, rlast on beat 3.
//  2 WRAP read araddr=0x38,len=3,size=2 -> beat addresses 0x38,0x3C,0x30,0x34.
//  3 Narrow write awaddr=0x21,size=0,len=1,wstrb 2 then 4 -> bytes 0x21,0x22 updated; bytes 0x20,0x23 unchanged.
//  4 rready low 3 cycles mid-burst -> rdata/rlast/rid stable; bready low 5 cycles -> bvalid held, no new AW accepted.
//  5 RANGE_CHK_EN: write to MEM_BYTES+4 -> bresp=2'b10, memory unchanged; undefined: same write lands at 0x4, bresp=0.
//  6 arst pulsed low during W_DATA beat 2 -> all outputs 0; awready=1 one cycle after release; next burst completes normally.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 slave responder backed by a byte-addressable memory.
// Write and read channels run independently; one burst in flight on each.
// Ports:
//   aclk, arst (async, active-low)
//   AW: awid/awaddr/awlen/awsize/awburst, awvalid/awready
//   W : wid/wdata/wstrb/wlast, wvalid/wready (wid, wlast informational only)
//   B : bid/bresp/bvalid, bready
//   AR: arid/araddr/arlen/arsize/arburst, arvalid/arready
//   R : rid/rdata/rresp/rlast/rvalid, rready
// Build option: define AXI_SLV_RANGE_CHK_EN to flag beats at addr >= MEM_BYTES as
// SLVERR (write beat dropped, read data zero); otherwise addresses wrap modulo MEM_BYTES.
module axi_slave_mem #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ID_W      = 4
) (
   input  logic            aclk,
   input  logic            arst,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [3:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   input  logic            awvalid,
   output logic            awready,
   input  logic [ID_W-1:0] wid,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [3:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   input  logic            arvalid,
   output logic            arready,
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready
);

   localparam int unsigned IDX_W = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

   logic [7:0] mem [MEM_BYTES];

   // Next beat address for FIXED/INCR/WRAP; reserved burst type behaves as INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                             input logic [3:0] len, input logic [1:0] bt);
      logic [2:0]  s;
      logic [31:0] bytes;
      logic [31:0] bound;
      logic [31:0] res;
      s     = (sz > 3'd2) ? 3'd2 : sz;
      bytes = 32'd1 << s;
      bound = (32'(len) + 32'd1) * bytes;
      res   = (a & ~(bytes - 32'd1)) + bytes;
      if (bt == 2'b00) begin
         res = a;
      end else if (bt == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
         res = (a & ~(bound - 32'd1)) | ((a + bytes) & (bound - 32'd1));
      end
      return res;
   endfunction

   // Write channel state
   wstate_e         wstate_q, wstate_d;
   logic [ID_W-1:0] wr_id_q, wr_id_d;
   logic [31:0]     wr_addr_q, wr_addr_d;
   logic [3:0]      wr_len_q, wr_len_d;
   logic [2:0]      wr_size_q, wr_size_d;
   logic [1:0]      wr_burst_q, wr_burst_d;
   logic [3:0]      wr_beat_q, wr_beat_d;
   logic            wr_err_q, wr_err_d;
   logic            awready_q, awready_d;
   logic            wready_q, wready_d;
   logic            bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [ID_W-1:0] bid_q, bid_d;
   logic            mem_we_c;
   logic            wr_oob_c;
   logic [IDX_W-1:0] wr_idx_c;

   // Read channel state
   rstate_e         rstate_q, rstate_d;
   logic [31:0]     rd_addr_q, rd_addr_d;
   logic [3:0]      rd_len_q, rd_len_d;
   logic [2:0]      rd_size_q, rd_size_d;
   logic [1:0]      rd_burst_q, rd_burst_d;
   logic [3:0]      rd_beat_q, rd_beat_d;
   logic            arready_q, arready_d;
   logic            rvalid_q, rvalid_d;
   logic            rlast_q, rlast_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [1:0]      rresp_q, rresp_d;
   logic [ID_W-1:0] rid_q, rid_d;
   logic            rd_load_c;
   logic [31:0]     rd_load_addr_c;
   logic            rd_oob_c;
   logic [IDX_W-1:0] rd_idx_c;
   logic [31:0]     rd_word_c;

   logic unused_ok;
   assign unused_ok = ^{wid, wlast};

   // Write FSM next-state and outputs
   always_comb begin
      wstate_d   = wstate_q;
      wr_id_d    = wr_id_q;
      wr_addr_d  = wr_addr_q;
      wr_len_d   = wr_len_q;
      wr_size_d  = wr_size_q;
      wr_burst_d = wr_burst_q;
      wr_beat_d  = wr_beat_q;
      wr_err_d   = wr_err_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      bid_d      = bid_q;
      mem_we_c   = 1'b0;
`ifdef AXI_SLV_RANGE_CHK_EN
      wr_oob_c   = (wr_addr_q >= 32'(MEM_BYTES));
`else
      wr_oob_c   = 1'b0;
`endif
      wr_idx_c   = IDX_W'({wr_addr_q[31:2], 2'b00});
      case (wstate_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (awvalid && awready_q) begin
               wr_id_d    = awid;
               wr_addr_d  = awaddr;
               wr_len_d   = awlen;
               wr_size_d  = awsize;
               wr_burst_d = awburst;
               wr_beat_d  = 4'd0;
               wr_err_d   = 1'b0;
               awready_d  = 1'b0;
               wready_d   = 1'b1;
               wstate_d   = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid && wready_q) begin
               mem_we_c  = !wr_oob_c;
               wr_err_d  = wr_err_q | wr_oob_c;
               wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_len_q, wr_burst_q);
               wr_beat_d = wr_beat_q + 4'd1;
               // Beat counter alone terminates the burst
               if (wr_beat_q == wr_len_q) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bid_d    = wr_id_q;
                  bresp_d  = (wr_err_q || wr_oob_c) ? 2'b10 : 2'b00;
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Read FSM next-state and outputs; rdata is loaded on accept and on each advance
   always_comb begin
      rstate_d       = rstate_q;
      rd_addr_d      = rd_addr_q;
      rd_len_d       = rd_len_q;
      rd_size_d      = rd_size_q;
      rd_burst_d     = rd_burst_q;
      rd_beat_d      = rd_beat_q;
      arready_d      = arready_q;
      rvalid_d       = rvalid_q;
      rlast_d        = rlast_q;
      rdata_d        = rdata_q;
      rresp_d        = rresp_q;
      rid_d          = rid_q;
      rd_load_c      = 1'b0;
      rd_load_addr_c = rd_addr_q;
      case (rstate_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (arvalid && arready_q) begin
               rd_addr_d      = araddr;
               rd_len_d       = arlen;
               rd_size_d      = arsize;
               rd_burst_d     = arburst;
               rd_beat_d      = 4'd0;
               rd_load_c      = 1'b1;
               rd_load_addr_c = araddr;
               rid_d          = arid;
               rlast_d        = (arlen == 4'd0);
               rvalid_d       = 1'b1;
               arready_d      = 1'b0;
               rstate_d       = R_DATA;
            end
         end
         R_DATA: begin
            if (rvalid_q && rready) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  rd_load_addr_c = next_addr(rd_addr_q, rd_size_q, rd_len_q, rd_burst_q);
                  rd_addr_d      = rd_load_addr_c;
                  rd_load_c      = 1'b1;
                  rd_beat_d      = rd_beat_q + 4'd1;
                  rlast_d        = ((rd_beat_q + 4'd1) == rd_len_q);
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase

`ifdef AXI_SLV_RANGE_CHK_EN
      rd_oob_c = (rd_load_addr_c >= 32'(MEM_BYTES));
`else
      rd_oob_c = 1'b0;
`endif
      rd_idx_c  = IDX_W'({rd_load_addr_c[31:2], 2'b00});
      rd_word_c = '0;
      for (int i = 0; i < 4; i++) begin
         rd_word_c[8*i +: 8] = mem[rd_idx_c + IDX_W'(i)];
      end
      if (rd_load_c) begin
         rdata_d = rd_oob_c ? 32'd0 : rd_word_c;
         rresp_d = rd_oob_c ? 2'b10 : 2'b00;
      end
   end

   // Control and output registers
   always_ff @(posedge aclk or negedge arst) begin
      if (!arst) begin
         wstate_q   <= W_IDLE;
         wr_id_q    <= '0;
         wr_addr_q  <= '0;
         wr_len_q   <= '0;
         wr_size_q  <= '0;
         wr_burst_q <= '0;
         wr_beat_q  <= '0;
         wr_err_q   <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         bid_q      <= '0;
         rstate_q   <= R_IDLE;
         rd_addr_q  <= '0;
         rd_len_q   <= '0;
         rd_size_q  <= '0;
         rd_burst_q <= '0;
         rd_beat_q  <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rid_q      <= '0;
      end else begin
         wstate_q   <= wstate_d;
         wr_id_q    <= wr_id_d;
         wr_addr_q  <= wr_addr_d;
         wr_len_q   <= wr_len_d;
         wr_size_q  <= wr_size_d;
         wr_burst_q <= wr_burst_d;
         wr_beat_q  <= wr_beat_d;
         wr_err_q   <= wr_err_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         bid_q      <= bid_d;
         rstate_q   <= rstate_d;
         rd_addr_q  <= rd_addr_d;
         rd_len_q   <= rd_len_d;
         rd_size_q  <= rd_size_d;
         rd_burst_q <= rd_burst_d;
         rd_beat_q  <= rd_beat_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rid_q      <= rid_d;
      end
   end

   // Memory array: not reset; lanes written as the strobes say
   always_ff @(posedge aclk) begin
      if (mem_we_c) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[wr_idx_c + IDX_W'(i)] <= wdata[8*i +: 8];
         end
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign bid     = bid_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rid     = rid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: randomized bench for axi_slave_mem against a byte-array reference model.
module tb_axi_slave_mem;
   localparam int unsigned MEM_BYTES = 1024;
   localparam int unsigned ID_W      = 4;
   localparam int          TMO       = 200;

   logic            aclk, arst;
   logic [ID_W-1:0] awid, wid, bid, arid, rid;
   logic [31:0]     awaddr, wdata, araddr, rdata;
   logic [3:0]      awlen, wstrb, arlen;
   logic [2:0]      awsize, arsize;
   logic [1:0]      awburst, arburst, bresp, rresp;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rlast, rvalid, rready;

   axi_slave_mem #(.MEM_BYTES(MEM_BYTES), .ID_W(ID_W)) dut (
      .aclk(aclk), .arst(arst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic [7:0]  ref_mem [MEM_BYTES];
   logic [31:0] wr_data_buf [16];
   logic [3:0]  wr_strb_buf [16];
   logic [31:0] last_rdata;
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference address sequence, straight from the burst rules
   function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [3:0] len, input logic [1:0] bt);
      int unsigned bytes, bound;
      bytes = 1 << ((sz > 3'd2) ? 2 : int'(sz));
      bound = (int'(len) + 1) * bytes;
      if (bt == 2'b00) return a;
      if (bt == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15))
         return (a / bound) * bound + ((a + bytes) % bound);
      return (a / bytes) * bytes + bytes;
   endfunction

   function automatic bit model_oob(input logic [31:0] a);
`ifdef AXI_SLV_RANGE_CHK_EN
      return a >= MEM_BYTES;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      int unsigned base;
      logic [31:0] w;
      base = ((a / 4) * 4) % MEM_BYTES;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[base + i];
      return w;
   endfunction

   task automatic wait_sig(input string tag, ref logic s);
      int t;
      t = 0;
      while (s !== 1'b1 && t < TMO) begin
         @(posedge aclk); #1; t++;
      end
      if (t >= TMO) chk(tag, 32'(s), 32'd1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bready_dly);
      logic [31:0] a;
      bit err;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      wait_sig("aw_timeout", awready);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      a = addr; err = 0;
      for (int b = 0; b <= int'(len); b++) begin
         wid = id; wdata = wr_data_buf[b]; wstrb = wr_strb_buf[b];
         wlast = (b == int'(len)); wvalid = 1'b1;
         wait_sig("w_timeout", wready);
         @(posedge aclk); #1;
         if (model_oob(a)) err = 1;
         else for (int i = 0; i < 4; i++)
            if (wr_strb_buf[b][i]) ref_mem[((a / 4) * 4 + i) % MEM_BYTES] = wr_data_buf[b][8*i +: 8];
         a = model_next(a, size, len, burst);
      end
      wvalid = 1'b0; wlast = 1'b0;
      wait_sig("b_timeout", bvalid);
      for (int d = 0; d < bready_dly; d++) begin
         chk("bvalid_hold", 32'(bvalid), 32'd1);
         chk("aw_blocked", 32'(awready), 32'd0);
         @(posedge aclk); #1;
      end
      chk("bid", 32'(bid), 32'(id));
      chk("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      chk("bvalid_drop", 32'(bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_cyc);
      logic [31:0] a, exp;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      wait_sig("ar_timeout", arready);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         wait_sig("r_timeout", rvalid);
         exp = model_oob(a) ? 32'd0 : model_word(a);
         chk("rdata", rdata, exp);
         chk("rresp", 32'(rresp), model_oob(a) ? 32'd2 : 32'd0);
         chk("rlast", 32'(rlast), 32'(b == int'(len)));
         chk("rid", 32'(rid), 32'(id));
         last_rdata = rdata;
         if (b == stall_beat) begin
            for (int k = 0; k < stall_cyc; k++) begin
               @(posedge aclk); #1;
               chk("rdata_hold", rdata, exp);
               chk("rlast_hold", 32'(rlast), 32'(b == int'(len)));
               chk("rid_hold", 32'(rid), 32'(id));
            end
         end
         rready = 1'b1;
         @(posedge aclk); #1;
         rready = 1'b0;
         a = model_next(a, size, len, burst);
      end
      chk("rvalid_drop", 32'(rvalid), 32'd0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_hs"}, 32'({awready, wready, bvalid, arready, rvalid, rlast}), 32'd0);
      chk({tag, "_b"}, 32'({bid, bresp}), 32'd0);
      chk({tag, "_r"}, 32'({rid, rresp}), 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
   endtask

   initial begin
      logic [3:0]  r_len;
      logic [2:0]  r_size;
      logic [1:0]  r_burst;
      logic [31:0] r_addr;
      arst = 1'b0;
      {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
      {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
      {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk_outputs_zero("reset");
      arst = 1'b1;
      chk("awready_rel0", 32'(awready), 32'd0);
      @(posedge aclk); #1;
      chk("awready_rel1", 32'(awready), 32'd1);
      chk("arready_rel1", 32'(arready), 32'd1);

      // Fill memory so every byte is known
      for (int blk = 0; blk < int'(MEM_BYTES / 64); blk++) begin
         for (int b = 0; b < 16; b++) begin wr_data_buf[b] = $urandom; wr_strb_buf[b] = 4'hF; end
         do_write(4'(blk), 32'(blk * 64), 4'd15, 3'd2, 2'b01, 0);
      end

      // INCR write A0..A3 and read back
      for (int b = 0; b < 4; b++) begin wr_data_buf[b] = 32'hA0 + 32'(b); wr_strb_buf[b] = 4'hF; end
      do_write(4'h5, 32'h10, 4'd3, 3'd2, 2'b01, 0);
      do_read(4'h6, 32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
      chk("incr_last_const", last_rdata, 32'hA3);

      // WRAP read starting at 0x38 over distinct words
      for (int b = 0; b < 4; b++) begin wr_data_buf[b] = 32'hC0DE_0030 + 32'(4 * b); wr_strb_buf[b] = 4'hF; end
      do_write(4'h1, 32'h30, 4'd3, 3'd2, 2'b01, 0);
      do_read(4'h2, 32'h38, 4'd3, 3'd2, 2'b10, -1, 0);
      chk("wrap_last_const", last_rdata, 32'hC0DE_0034);

      // Narrow byte writes inside a known word
      wr_data_buf[0] = 32'hDEAD_BEEF; wr_strb_buf[0] = 4'hF;
      do_write(4'h3, 32'h20, 4'd0, 3'd2, 2'b01, 0);
      wr_data_buf[0] = 32'h0000_AA00; wr_strb_buf[0] = 4'h2;
      wr_data_buf[1] = 32'h00BB_0000; wr_strb_buf[1] = 4'h4;
      do_write(4'h4, 32'h21, 4'd1, 3'd0, 2'b01, 0);
      do_read(4'h4, 32'h20, 4'd0, 3'd2, 2'b01, -1, 0);
      chk("narrow_const", last_rdata, 32'hDEBB_AAEF);

      // Back-pressure on R and B
      do_read(4'h7, 32'h40, 4'd3, 3'd2, 2'b01, 1, 3);
      for (int b = 0; b < 2; b++) begin wr_data_buf[b] = $urandom; wr_strb_buf[b] = 4'hF; end
      do_write(4'h8, 32'h60, 4'd1, 3'd2, 2'b01, 5);

      // Out-of-range write and the aliased word
      wr_data_buf[0] = 32'h5A5A_5A5A; wr_strb_buf[0] = 4'hF;
      do_write(4'h9, 32'(MEM_BYTES + 4), 4'd0, 3'd2, 2'b01, 0);
      do_read(4'h9, 32'h4, 4'd0, 3'd2, 2'b01, -1, 0);
      do_read(4'hA, 32'(MEM_BYTES + 4), 4'd0, 3'd2, 2'b01, -1, 0);

      // Reset during write beat 2
      for (int b = 0; b < 8; b++) begin wr_data_buf[b] = $urandom; wr_strb_buf[b] = 4'hF; end
      awid = 4'hB; awaddr = 32'h80; awlen = 4'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
      wait_sig("aw_timeout", awready);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         wdata = wr_data_buf[b]; wstrb = 4'hF; wvalid = 1'b1;
         wait_sig("w_timeout", wready);
         @(posedge aclk); #1;
         for (int i = 0; i < 4; i++) ref_mem[32'h80 + 4 * b + i] = wr_data_buf[b][8*i +: 8];
      end
      wdata = wr_data_buf[2]; wvalid = 1'b1;
      #2 arst = 1'b0;
      #1 chk_outputs_zero("mid_reset");
      wvalid = 1'b0;
      @(posedge aclk); #1;
      arst = 1'b1;
      chk("awready_rel0b", 32'(awready), 32'd0);
      @(posedge aclk); #1;
      chk("awready_rel1b", 32'(awready), 32'd1);
      do_read(4'hC, 32'h80, 4'd7, 3'd2, 2'b01, -1, 0);
      for (int b = 0; b < 4; b++) begin wr_data_buf[b] = $urandom; wr_strb_buf[b] = 4'hF; end
      do_write(4'hD, 32'h80, 4'd3, 3'd2, 2'b01, 0);
      do_read(4'hD, 32'h80, 4'd3, 3'd2, 2'b01, -1, 0);

      // Concurrent write and read on disjoint regions
      for (int b = 0; b < 8; b++) begin wr_data_buf[b] = $urandom; wr_strb_buf[b] = 4'(b + 1); end
      fork
         do_write(4'hE, 32'h100, 4'd7, 3'd2, 2'b01, 1);
         do_read(4'hF, 32'h200, 4'd7, 3'd2, 2'b10, 2, 2);
      join
      do_read(4'h1, 32'h100, 4'd7, 3'd2, 2'b01, -1, 0);

      // Random bursts
      for (int n = 0; n < 60; n++) begin
         r_len   = 4'($urandom_range(0, 15));
         r_size  = 3'($urandom_range(0, 3));
         r_burst = 2'($urandom_range(0, 3));
         r_addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 2 * MEM_BYTES - 1))
                                               : 32'($urandom_range(0, MEM_BYTES - 1));
         for (int b = 0; b < 16; b++) begin wr_data_buf[b] = $urandom; wr_strb_buf[b] = 4'($urandom); end
         do_write(4'($urandom), r_addr, r_len, r_size, r_burst, $urandom_range(0, 2));
         do_read(4'($urandom), r_addr, r_len, r_size, r_burst,
                 $urandom_range(0, 15), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
